// File: rtl/instr_fetch_ir.sv
`default_nettype none
// ============================================================================
// Module      : instr_fetch_ir
// Description : Instruction fetch and instruction register stage of the
//               64-bit RISC-V core. Holds the PC and fetches 32-bit words
//               from instruction memory over a req/ack handshake. Latches
//               each returned word into the instruction register, which
//               feeds the immediate sign-extender and the decoder. Also
//               handles branch/jump redirects and flags memory timeouts.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports:
//   clk          in   1   core clock; all state changes on the rising edge
//   reset        in   1   synchronous, active-high
//   mem_req      out  1   instruction-memory request
//   mem_addr     out  64  fetch address, always 4-byte aligned
//   mem_ack      in   1   response valid; looked at only while mem_req=1
//   mem_rdata    in   32  instruction word, valid in the mem_ack cycle
//   ir_out       out  32  latched instruction word
//   ir_pc        out  64  PC of the instruction held in ir_out
//   ir_valid     out  1   ir_out holds an instruction not yet consumed
//   ir_ready     in   1   downstream accepts ir_out this cycle
//   redirect     in   1   branch/jump taken: flush and refetch
//   redirect_pc  in  64   new PC; bits [1:0] are ignored
//   fetch_err    out  1   sticky memory-timeout flag
// ============================================================================
module instr_fetch_ir #(
    parameter logic [63:0] RESET_PC = 64'h0,
    parameter int unsigned TIMEOUT  = 16     // legal range 2..255
) (
    input  logic        clk,
    input  logic        reset,
    output logic        mem_req,
    output logic [63:0] mem_addr,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic [31:0] ir_out,
    output logic [63:0] ir_pc,
    output logic        ir_valid,
    input  logic        ir_ready,
    input  logic        redirect,
    input  logic [63:0] redirect_pc,
    output logic        fetch_err
);

    // ------------------------------------------------------------------
    // State encoding and constants
    // ------------------------------------------------------------------
    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_REQ  = 2'd1;
    localparam logic [1:0] c_ST_HOLD = 2'd2;
    localparam logic [1:0] c_ST_ERR  = 2'd3;

    // Last counter value that still belongs to the request window. With
    // the counter starting at 0 in the first REQ cycle, mem_req stays high
    // for exactly TIMEOUT cycles.
    localparam logic [7:0]  c_TO_LAST    = 8'(TIMEOUT - 1);
    localparam logic [63:0] c_ALIGN_MASK = ~64'h3;
    localparam logic [63:0] c_PC_STEP    = 64'd4;

    // ------------------------------------------------------------------
    // Registered state
    // ------------------------------------------------------------------
    logic [1:0]  r_state;
    logic [63:0] r_pc;
    logic [31:0] r_ir;
    logic [63:0] r_ir_pc;
    logic        r_ir_valid;
    logic        r_mem_req;
    logic        r_fetch_err;
    logic [7:0]  r_cnt;

    // ------------------------------------------------------------------
    // Next-state values
    // ------------------------------------------------------------------
    logic [1:0]  w_state_nxt;
    logic [63:0] w_pc_nxt;
    logic [31:0] w_ir_nxt;
    logic [63:0] w_ir_pc_nxt;
    logic        w_ir_valid_nxt;
    logic        w_fetch_err_nxt;
    logic [7:0]  w_cnt_nxt;

    always_comb begin
        w_state_nxt     = r_state;
        w_pc_nxt        = r_pc;
        w_ir_nxt        = r_ir;
        w_ir_pc_nxt     = r_ir_pc;
        w_ir_valid_nxt  = r_ir_valid;
        w_fetch_err_nxt = r_fetch_err;
        w_cnt_nxt       = r_cnt;

        if (redirect) begin
            // A redirect overrides everything in flight: a same-cycle ack
            // is dropped and a same-cycle ir_ready is a flush, not a consume.
            w_state_nxt     = c_ST_IDLE;
            w_pc_nxt        = redirect_pc & c_ALIGN_MASK;
            w_ir_valid_nxt  = 1'b0;
            w_fetch_err_nxt = 1'b0;
            w_cnt_nxt       = 8'd0;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    // Single bubble cycle before a request goes out.
                    w_state_nxt = c_ST_REQ;
                    w_cnt_nxt   = 8'd0;
                end

                c_ST_REQ: begin
                    if (mem_ack) begin
                        // An ack wins over the timeout in the final cycle.
                        w_ir_nxt       = mem_rdata;
                        w_ir_pc_nxt    = r_pc;
                        w_pc_nxt       = r_pc + c_PC_STEP;
                        w_ir_valid_nxt = 1'b1;
                        w_cnt_nxt      = 8'd0;
                        w_state_nxt    = c_ST_HOLD;
                    end else if (r_cnt == c_TO_LAST) begin
                        w_fetch_err_nxt = 1'b1;
                        w_cnt_nxt       = 8'd0;
                        w_state_nxt     = c_ST_ERR;
                    end else begin
                        w_cnt_nxt = r_cnt + 8'd1;
                    end
                end

                c_ST_HOLD: begin
                    if (r_ir_valid && ir_ready) begin
                        w_ir_valid_nxt = 1'b0;
                        w_state_nxt    = c_ST_REQ;
                    end
                end

                c_ST_ERR: begin
                    // Parked until a redirect or reset arrives.
                    w_fetch_err_nxt = 1'b1;
                    w_ir_valid_nxt  = 1'b0;
                end

                default: begin
                    w_state_nxt = c_ST_IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // State register. mem_req is held in its own flop so that it is a clean
    // registered output, and it is loaded from the next-state decode so it
    // always matches the REQ state.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= c_ST_IDLE;
            r_pc        <= RESET_PC & c_ALIGN_MASK;
            r_ir        <= 32'd0;
            r_ir_pc     <= 64'd0;
            r_ir_valid  <= 1'b0;
            r_mem_req   <= 1'b0;
            r_fetch_err <= 1'b0;
            r_cnt       <= 8'd0;
        end else begin
            r_state     <= w_state_nxt;
            r_pc        <= w_pc_nxt;
            r_ir        <= w_ir_nxt;
            r_ir_pc     <= w_ir_pc_nxt;
            r_ir_valid  <= w_ir_valid_nxt;
            r_mem_req   <= (w_state_nxt == c_ST_REQ);
            r_fetch_err <= w_fetch_err_nxt;
            r_cnt       <= w_cnt_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign mem_req   = r_mem_req;
    assign mem_addr  = r_pc;
    assign ir_out    = r_ir;
    assign ir_pc     = r_ir_pc;
    assign ir_valid  = r_ir_valid;
    assign fetch_err = r_fetch_err;

endmodule
`default_nettype wire
